// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multi-digit seven-segment counter.
// Segment order is {g,f,e,d,c,b,a}, active high.
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seven_segment_counter_mux_if.sv
// Control inputs and display/count outputs of the multi-digit counter.
// The counter itself connects through the slave modport.
interface seven_segment_counter_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      run;
    logic                      up_down;
    logic                      clear;
    logic [4*NUM_DIGITS-1:0]   count_bcd;
    logic                      tick;
    logic                      rollover;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     digit_sel;

    modport master (
        output run, up_down, clear,
        input  count_bcd, tick, rollover, seg, dp, digit_sel
    );

    modport slave (
        input  run, up_down, clear,
        output count_bcd, tick, rollover, seg, dp, digit_sel
    );
endinterface

// File: rtl/bcd_digit.sv
// One decimal digit of the counter chain: steps when enabled and the
// lower digits carry/borrow into it, and reports its own carry/borrow out.
module bcd_digit
    import seven_seg_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic up,
    input  logic cin,
    output bcd_t q,
    output logic cout
);

    assign cout = cin & (up ? (q == BCD_MAX) : (q == 4'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 4'd0;
        end else if (clear) begin
            q <= 4'd0;
        end else if (en && cin) begin
            if (up)
                q <= (q >= BCD_MAX) ? 4'd0 : q + 4'd1;
            else
                q <= (q == 4'd0 || q > BCD_MAX) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/seg7.sv
// BCD to seven-segment decoder, segments {g,f,e,d,c,b,a} active high.
// Non-decimal codes decode to all segments off.
module seg7
    import seven_seg_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_counter_mux.sv
// N-digit BCD up/down counter with prescaled tick and a time-multiplexed
// seven-segment scan with optional leading-zero blanking.
module seven_segment_counter_mux
    import seven_seg_pkg::*;
#(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
    parameter int          NUM_DIGITS = 4,
    parameter logic [15:0] SCAN_COUNT = 16'd10_000,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    seven_segment_counter_mux_if.slave  bus
);

    localparam int PW = $clog2(32'(TICK_COUNT) + 32'd1);
    localparam int SW = (SCAN_COUNT > 16'd1) ? $clog2(32'(SCAN_COUNT)) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         TC       = PW'(TICK_COUNT);
    localparam logic [SW-1:0]         SC_LAST  = SW'(SCAN_COUNT - 16'd1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

    logic [PW-1:0]           presc_q;
    logic                    tick_q;
    logic                    rollover_q;
    bcd_t                    digit_q [NUM_DIGITS];
    logic [NUM_DIGITS:0]     carry;
    logic [4*NUM_DIGITS-1:0] count_bcd;
    logic [SW-1:0]           scan_cnt;
    logic [IW-1:0]           idx;
    logic [NUM_DIGITS-1:0]   lz;
    bcd_t                    sel_digit;
    logic                    blank_sel;
    logic [6:0]              seg_dec;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   digit_sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else if (bus.clear) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else if (bus.run) begin
            if (presc_q == TC) begin
                presc_q <= '0;
                tick_q  <= 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
                tick_q  <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    // Carry/borrow ripples combinationally so the whole chain settles in one step.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clear (bus.clear),
            .en    (tick_q),
            .up    (bus.up_down),
            .cin   (carry[g]),
            .q     (digit_q[g]),
            .cout  (carry[g+1])
        );
    end

    always_comb begin
        count_bcd = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            count_bcd[4*i +: 4] = digit_q[i];
    end

    always_ff @(posedge clk) begin
        if (reset)
            rollover_q <= 1'b0;
        else if (bus.clear)
            rollover_q <= 1'b0;
        else
            rollover_q <= tick_q & carry[NUM_DIGITS];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SC_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // lz[i]: digit i and every digit above it are zero.
    always_comb begin
        lz = '0;
        lz[NUM_DIGITS-1] = (digit_q[NUM_DIGITS-1] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            lz[i] = lz[i+1] & (digit_q[i] == 4'd0);
    end

    assign sel_digit = digit_q[idx];
    assign blank_sel = BLANK_LZ && (idx != '0) && lz[idx];

    seg7 u_seg7 (
        .digit (sel_digit),
        .seg   (seg_dec)
    );

    // Segments, dp and enable all come from the same idx so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b0;
            digit_sel_q <= '0;
        end else begin
            seg_q       <= blank_sel ? SEG_BLANK : seg_dec;
            dp_q        <= (idx == '0) && !bus.run;
            digit_sel_q <= SEL_ONE << idx;
        end
    end

    assign bus.count_bcd = count_bcd;
    assign bus.tick      = tick_q;
    assign bus.rollover  = rollover_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.digit_sel = digit_sel_q;

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Directed bench for the 2-digit counter/scan configuration, with a second
// instance that shows leading zeros.
module tb_seven_segment_counter_mux;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic up_down = 1'b1;
    logic clear = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    seven_segment_counter_mux_if #(.NUM_DIGITS(2)) bus ();
    seven_segment_counter_mux_if #(.NUM_DIGITS(2)) bus_nb ();

    assign bus.run        = run;
    assign bus.up_down    = up_down;
    assign bus.clear      = clear;
    assign bus_nb.run     = run;
    assign bus_nb.up_down = up_down;
    assign bus_nb.clear   = clear;

    seven_segment_counter_mux #(
        .TICK_COUNT (24'd3),
        .NUM_DIGITS (2),
        .SCAN_COUNT (16'd2),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seven_segment_counter_mux #(
        .TICK_COUNT (24'd3),
        .NUM_DIGITS (2),
        .SCAN_COUNT (16'd2),
        .BLANK_LZ   (1'b0)
    ) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb)
    );

    // Edges since reset release; drives the expected scan position.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [1:0] exp_sel(int c);
        return ((((c - 1) / 2) % 2) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick(input string tag, output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            waited++;
            if (bus.tick === 1'b1) found = 1'b1;
        end
        check({tag, "_tick_seen"}, 32'(found), 32'd1);
    endtask

    task automatic next_count(input string tag, input logic [7:0] exp_cnt,
                              input logic exp_roll, input int exp_wait);
        int waited;
        wait_tick(tag, waited);
        if (exp_wait > 0) check({tag, "_period"}, waited, exp_wait);
        @(negedge clk);
        check({tag, "_cnt"}, 32'(bus.count_bcd), 32'(exp_cnt));
        check({tag, "_roll"}, 32'(bus.rollover), 32'(exp_roll));
        check({tag, "_tick_low"}, 32'(bus.tick), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        logic [1:0] es;

        // Reset held for three edges
        reset = 1'b1;
        run = 1'b0;
        up_down = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_count", 32'(bus.count_bcd), 32'h0);
        check("rst_tick", 32'(bus.tick), 32'h0);
        check("rst_roll", 32'(bus.rollover), 32'h0);
        check("rst_seg", 32'(bus.seg), 32'h0);
        check("rst_dp", 32'(bus.dp), 32'h0);
        check("rst_sel", 32'(bus.digit_sel), 32'h0);

        reset = 1'b0;
        run = 1'b1;
        @(negedge clk);
        check("first_sel", 32'(bus.digit_sel), 32'h1);
        check("first_seg", 32'(bus.seg), 32'h3F);
        check("first_dp", 32'(bus.dp), 32'h0);
        check("pre_tick1", 32'(bus.tick), 32'h0);
        @(negedge clk);
        check("pre_tick2", 32'(bus.tick), 32'h0);
        @(negedge clk);
        check("pre_tick3", 32'(bus.tick), 32'h0);
        @(negedge clk);
        check("first_tick", 32'(bus.tick), 32'h1);
        check("first_tick_cnt", 32'(bus.count_bcd), 32'h0);
        @(negedge clk);
        check("first_cnt", 32'(bus.count_bcd), 32'h01);
        check("first_tick_low", 32'(bus.tick), 32'h0);

        // Count up to 99, then wrap both directions
        for (int i = 2; i <= 99; i++)
            next_count("count_up", to_bcd(i), 1'b0, 3);
        next_count("wrap_up", 8'h00, 1'b1, 3);
        @(negedge clk);
        check("wrap_up_pulse", 32'(bus.rollover), 32'h0);
        up_down = 1'b0;
        next_count("wrap_down", 8'h99, 1'b1, 2);
        up_down = 1'b1;
        next_count("wrap_up2", 8'h00, 1'b1, 3);

        // Carry and borrow across the digit boundary
        for (int i = 1; i <= 9; i++)
            next_count("up_to_9", to_bcd(i), 1'b0, 3);
        next_count("carry", 8'h10, 1'b0, 3);
        up_down = 1'b0;
        next_count("borrow", 8'h09, 1'b0, 3);
        up_down = 1'b1;
        next_count("carry2", 8'h10, 1'b0, 3);
        check("nb_count", 32'(bus_nb.count_bcd), 32'h10);

        // Pause mid-prescale
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            es = exp_sel(cyc);
            check("pause_tick", 32'(bus.tick), 32'h0);
            check("pause_cnt", 32'(bus.count_bcd), 32'h10);
            check("pause_sel", 32'(bus.digit_sel), 32'(es));
            if (es == 2'b01) begin
                check("pause_dp_on", 32'(bus.dp), 32'h1);
                check("pause_seg_d0", 32'(bus.seg), 32'h3F);
            end else begin
                check("pause_dp_off", 32'(bus.dp), 32'h0);
                check("pause_seg_d1", 32'(bus.seg), 32'h06);
            end
        end
        run = 1'b1;
        next_count("resume", 8'h11, 1'b0, 3);

        for (int i = 12; i <= 42; i++)
            next_count("count_42", to_bcd(i), 1'b0, 3);

        // Clear coincident with tick
        wait_tick("clr", waited);
        check("clr_at_tick_cnt", 32'(bus.count_bcd), 32'h42);
        clear = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("clr_cnt", 32'(bus.count_bcd), 32'h0);
            check("clr_roll", 32'(bus.rollover), 32'h0);
            check("clr_tick", 32'(bus.tick), 32'h0);
            check("clr_sel", 32'(bus.digit_sel), 32'(exp_sel(cyc)));
        end
        clear = 1'b0;
        wait_tick("clr_presc", waited);
        check("clr_presc_period", waited, 4);
        @(negedge clk);
        check("post_clr_cnt", 32'(bus.count_bcd), 32'h01);

        // Display at 07 with and without leading-zero blanking
        for (int i = 2; i <= 7; i++)
            next_count("count_7", to_bcd(i), 1'b0, 3);
        run = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            es = exp_sel(cyc);
            check("disp_sel", 32'(bus.digit_sel), 32'(es));
            check("disp_sel_nb", 32'(bus_nb.digit_sel), 32'(es));
            check("disp_dp", 32'(bus.dp), 32'(es == 2'b01));
            if (es == 2'b01) begin
                check("disp_seg_d0", 32'(bus.seg), 32'h07);
                check("disp_seg_d0_nb", 32'(bus_nb.seg), 32'h07);
            end else begin
                check("disp_seg_blank", 32'(bus.seg), 32'h00);
                check("disp_seg_zero_nb", 32'(bus_nb.seg), 32'h3F);
            end
        end

        // Random run/direction soak: digits must stay decimal
        for (int k = 0; k < 400; k++) begin
            run = 1'($urandom_range(0, 1));
            up_down = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("soak_d0", 32'(bus.count_bcd[3:0] <= 4'd9), 32'd1);
            check("soak_d1", 32'(bus.count_bcd[7:4] <= 4'd9), 32'd1);
            check("soak_nb", 32'(bus_nb.count_bcd), 32'(bus.count_bcd));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
